psum_axis_tx: RTL

Output drain for the systolic array. Captures the column-skewed `partialsum_out` / `partialsum_out_valid` results into per-column FIFOs, reassembles one result vector per array row-pass, and transmits it as an AXI4-Stream master packet. Two 16-bit sums are packed per 32-bit beat. It is the transmit-side counterpart of the array's `s_axis` receive port and feeds the DMA S2MM channel.

---
 rtl/psum_axis_pkg.sv | 16 +
 rtl/psum_col_fifo.sv | 48 ++++
 rtl/psum_axis_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/psum_axis_pkg.sv
// Shared types and helpers for the systolic-array result drain (psum_axis_tx).
package psum_axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    localparam int PSUM_W = 16;

    // Width of the beat counter: enough to index COLS/2 two-column beats.
    function automatic int beat_w(input int cols);
        return (cols / 2 <= 1) ? 1 : $clog2(cols / 2);
    endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Per-column result FIFO: PSUM_W x DEPTH, extra pointer bit distinguishes full/empty.
// A push into a full FIFO is accepted only when the same cycle pops it.
module psum_col_fifo
    import psum_axis_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [PSUM_W-1:0] din,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [PSUM_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [PSUM_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; data needs no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/psum_axis_tx.sv
// Systolic-array output drain: buffers column-skewed partial sums per column,
// reassembles one vector per row-pass and sends it as an AXI4-Stream packet,
// two 16-bit sums per 32-bit beat.
module psum_axis_tx
    import psum_axis_pkg::*;
#(
    parameter int COLS  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COLS*PSUM_W-1:0]   partialsum_in,
    input  logic [COLS-1:0]          partialsum_in_valid,
    input  logic [$clog2(COLS)-1:0]  last_col,
    output logic [31:0]              m_axis_tdata,
    output logic [3:0]               m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     overflow
);

    localparam int CW = $clog2(COLS);
    localparam int BW = beat_w(COLS);

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     l_q;
    logic [BW-1:0]     beat_q;
    logic [BW-1:0]     last_idx;
    logic              on_last;
    logic              fire;
    logic              fire_last;
    logic              complete;
    logic              drop;
    logic [COLS-1:0]   col_en;
    logic [COLS-1:0]   pop_en;
    logic [COLS-1:0]   push_req;
    logic [COLS-1:0]   pop;
    logic [COLS-1:0]   full;
    logic [COLS-1:0]   empty;
    logic [PSUM_W-1:0] head [COLS];
    logic [BW:0]       lo_idx;
    logic [BW:0]       hi_idx;

    for (genvar j = 0; j < COLS; j++) begin : g_col
        // Push gating follows the live last_col; popping follows the latched L.
        assign col_en[j]   = (CW'(j) <= last_col);
        assign pop_en[j]   = (CW'(j) <= l_q);
        assign push_req[j] = partialsum_in_valid[j] && col_en[j];
        assign pop[j]      = fire_last && pop_en[j];

        psum_col_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_req[j]),
            .din   (partialsum_in[j*PSUM_W +: PSUM_W]),
            .pop   (pop[j]),
            .full  (full[j]),
            .empty (empty[j]),
            .head  (head[j])
        );
    end

    // N-1 = floor(L/2): the beat index carrying column L.
    assign last_idx  = BW'(l_q >> 1);
    assign on_last   = (beat_q == last_idx);
    assign fire      = (state_q == SEND) && m_axis_tready;
    assign fire_last = fire && on_last;
    assign complete  = ((empty & col_en) == '0);
    assign drop      = |(push_req & full & ~pop);
    assign lo_idx    = {beat_q, 1'b0};
    assign hi_idx    = {beat_q, 1'b1};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: start when every active column holds a result, finish on the last handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (complete)  state_d = SEND;
            SEND:    if (fire_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Packet bookkeeping: latch L at packet start, advance the beat on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q    <= '0;
            beat_q <= '0;
        end else if (state_q == IDLE && complete) begin
            l_q    <= last_col;
            beat_q <= '0;
        end else if (fire) begin
            beat_q <= on_last ? '0 : beat_q + 1'b1;
        end
    end

    // Output mux: heads of the column pair for the current beat; odd tail half-beat masked.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = 4'h0;
        m_axis_tdata  = 32'h0;
        if (state_q == SEND) begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = on_last;
            if (on_last && !l_q[0]) begin
                m_axis_tkeep = 4'b0011;
                m_axis_tdata = {16'h0, head[lo_idx]};
            end else begin
                m_axis_tkeep = 4'b1111;
                m_axis_tdata = {head[hi_idx], head[lo_idx]};
            end
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

endmodule
